// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes non-memory ops through, runs load/store
// bus transactions, aligns store lanes, extends load data, registers writeback.
//   state  | meaning
//   S_IDLE | empty, ready to accept
//   S_REQ  | bus request asserted, waiting for grant
//   S_WAIT | granted, waiting for response
//   S_HOLD | writeback packet valid, waiting for out_ready
module mem_stage #(
  parameter bit STORE_WAIT_ACK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mem_read_ena,
  input  logic        in_mem_write_ena,
  input  logic [2:0]  in_mem_type,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_write_data,
  input  logic [31:0] in_result,
  input  logic        in_write_reg_need,
  input  logic [4:0]  in_write_reg_addr,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_write_reg_need,
  output logic [4:0]  out_write_reg_addr,
  output logic        out_addr_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  lo_q, lo_d;
  logic        store_q, store_d;
  logic [31:0] result_q, result_d;
  logic        need_q, need_d;
  logic [4:0]  wra_q, wra_d;

  logic        dbus_req_q, dbus_req_d;
  logic        dbus_we_q, dbus_we_d;
  logic [31:0] dbus_addr_q, dbus_addr_d;
  logic [3:0]  dbus_wstrb_q, dbus_wstrb_d;
  logic [31:0] dbus_wdata_q, dbus_wdata_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_need_q, out_need_d;
  logic [4:0]  out_wra_q, out_wra_d;
  logic        out_err_q, out_err_d;

  logic accept;
  logic mem_op;

  function automatic logic is_half(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd2);
  endfunction

  function automatic logic is_byte(input logic [2:0] t);
    return (t == 3'd3) || (t == 3'd4);
  endfunction

  // Byte accesses can never be misaligned; unknown type codes behave as word.
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    if (is_byte(t))      return 1'b0;
    else if (is_half(t)) return a[0];
    else                 return a != 2'b00;
  endfunction

  function automatic logic [3:0] strobes(input logic [2:0] t, input logic [1:0] a);
    if (is_byte(t))      return 4'b0001 << a;
    else if (is_half(t)) return a[1] ? 4'b1100 : 4'b0011;
    else                 return 4'b1111;
  endfunction

  function automatic logic [31:0] lanes(input logic [2:0] t, input logic [31:0] d);
    if (is_byte(t))      return {4{d[7:0]}};
    else if (is_half(t)) return {2{d[15:0]}};
    else                 return d;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] t, input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (t)
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd2:    return {16'h0000, sh[15:0]};
      3'd3:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'h000000, sh[7:0]};
      default: return sh;
    endcase
  endfunction

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign mem_op   = in_mem_read_ena || in_mem_write_ena;

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    lo_d         = lo_q;
    store_d      = store_q;
    result_d     = result_q;
    need_d       = need_q;
    wra_d        = wra_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_wstrb_d = dbus_wstrb_q;
    dbus_wdata_d = dbus_wdata_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_need_d   = out_need_q;
    out_wra_d    = out_wra_q;
    out_err_d    = out_err_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
        if (accept) begin
          type_d   = in_mem_type;
          lo_d     = in_addr[1:0];
          store_d  = in_mem_write_ena;
          result_d = in_result;
          need_d   = in_write_reg_need;
          wra_d    = in_write_reg_addr;
          if (!mem_op) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            out_data_d  = in_result;
            out_need_d  = in_write_reg_need;
            out_wra_d   = in_write_reg_addr;
            out_err_d   = 1'b0;
          end else if (misaligned(in_mem_type, in_addr[1:0])) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            out_data_d  = in_addr;
            out_need_d  = 1'b0;
            out_wra_d   = in_write_reg_addr;
            out_err_d   = 1'b1;
          end else begin
            // Write enable wins when both enables are set.
            state_d      = S_REQ;
            dbus_req_d   = 1'b1;
            dbus_we_d    = in_mem_write_ena;
            dbus_addr_d  = {in_addr[31:2], 2'b00};
            dbus_wstrb_d = in_mem_write_ena ? strobes(in_mem_type, in_addr[1:0]) : 4'b0000;
            dbus_wdata_d = in_mem_write_ena ? lanes(in_mem_type, in_write_data) : 32'h0;
          end
        end
      end
      S_REQ: begin
        if (dbus_gnt) begin
          dbus_req_d   = 1'b0;
          dbus_we_d    = 1'b0;
          dbus_addr_d  = 32'h0;
          dbus_wstrb_d = 4'b0000;
          dbus_wdata_d = 32'h0;
          if (store_q && !STORE_WAIT_ACK) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            out_data_d  = result_q;
            out_need_d  = need_q;
            out_wra_d   = wra_q;
            out_err_d   = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dbus_rvalid) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          out_data_d  = store_q ? result_q : extend(type_q, lo_q, dbus_rdata);
          out_need_d  = need_q;
          out_wra_d   = wra_q;
          out_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      type_q       <= 3'd0;
      lo_q         <= 2'd0;
      store_q      <= 1'b0;
      result_q     <= 32'h0;
      need_q       <= 1'b0;
      wra_q        <= 5'd0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= 32'h0;
      dbus_wstrb_q <= 4'b0000;
      dbus_wdata_q <= 32'h0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      out_need_q   <= 1'b0;
      out_wra_q    <= 5'd0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      lo_q         <= lo_d;
      store_q      <= store_d;
      result_q     <= result_d;
      need_q       <= need_d;
      wra_q        <= wra_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_wstrb_q <= dbus_wstrb_d;
      dbus_wdata_q <= dbus_wdata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_need_q   <= out_need_d;
      out_wra_q    <= out_wra_d;
      out_err_q    <= out_err_d;
    end
  end

  assign dbus_req           = dbus_req_q;
  assign dbus_we            = dbus_we_q;
  assign dbus_addr          = dbus_addr_q;
  assign dbus_wstrb         = dbus_wstrb_q;
  assign dbus_wdata         = dbus_wdata_q;
  assign out_valid          = out_valid_q;
  assign out_data           = out_data_q;
  assign out_write_reg_need = out_need_q;
  assign out_write_reg_addr = out_wra_q;
  assign out_addr_error     = out_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized packets against an
// arithmetic reference model, with a bus responder of random grant/response delay.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        in_mem_read_ena, in_mem_write_ena;
  logic [2:0]  in_mem_type;
  logic [31:0] in_addr, in_write_data, in_result;
  logic        in_write_reg_need;
  logic [4:0]  in_write_reg_addr;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_write_reg_need;
  logic [4:0]  out_write_reg_addr;
  logic        out_addr_error;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.STORE_WAIT_ACK(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read_ena(in_mem_read_ena), .in_mem_write_ena(in_mem_write_ena),
    .in_mem_type(in_mem_type), .in_addr(in_addr), .in_write_data(in_write_data),
    .in_result(in_result), .in_write_reg_need(in_write_reg_need),
    .in_write_reg_addr(in_write_reg_addr),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_write_reg_need(out_write_reg_need), .out_write_reg_addr(out_write_reg_addr),
    .out_addr_error(out_addr_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on byte offsets.
  function automatic logic [31:0] model_load(input int t, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] w;
    w = rd >> (8 * (a % 4));
    case (t)
      1:       return (w & 32'hFFFF) - ((w & 32'h8000) << 1);
      2:       return w & 32'hFFFF;
      3:       return (w & 32'hFF) - ((w & 32'h80) << 1);
      4:       return w & 32'hFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic model_misaligned(input int t, input logic [31:0] a);
    if (t == 0)           return (a % 4) != 0;
    if (t == 1 || t == 2) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_strb(input logic st, input int t, input logic [31:0] a);
    logic [3:0] s;
    if (!st)              s = 4'h0;
    else if (t == 0)      s = 4'hF;
    else if (t <= 2)      s = 4'h3 << (a % 4);
    else                  s = 4'h1 << (a % 4);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic st, input int t, input logic [31:0] d);
    if (!st)         return 32'h0;
    if (t == 0)      return d;
    if (t <= 2)      return (d & 32'hFFFF) * 32'h0001_0001;
    return (d & 32'hFF) * 32'h0101_0101;
  endfunction

  // Drive one packet at a negedge with the stage idle; respond on the bus after
  // gd/rvd cycles; hold out_ready low rdly cycles; optionally chain a
  // pass-through packet on the release cycle.
  task automatic run_pkt(input logic rd_e, input logic wr_e, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] res,
                         input logic need, input logic [4:0] wra,
                         input int gd, input int rvd, input int rdly,
                         input logic [31:0] rdata, input logic chain,
                         input logic [31:0] chain_res);
    logic is_mem, st, err, bus, exp_need;
    logic [31:0] exp_data;
    is_mem   = rd_e | wr_e;
    st       = wr_e;
    err      = is_mem && model_misaligned(int'(t), a);
    bus      = is_mem && !err;
    if (!is_mem)   exp_data = res;
    else if (err)  exp_data = a;
    else if (st)   exp_data = res;
    else           exp_data = model_load(int'(t), a, rdata);
    exp_need = err ? 1'b0 : need;

    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_mem_read_ena = rd_e; in_mem_write_ena = wr_e;
    in_mem_type = t; in_addr = a; in_write_data = wd; in_result = res;
    in_write_reg_need = need; in_write_reg_addr = wra; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr = $urandom; in_write_data = $urandom; in_result = $urandom;
    if (bus) begin
      for (int g = 0; g <= gd; g++) begin
        check("dbus_req", dbus_req, 1);
        check("dbus_addr", dbus_addr, a & ~32'h3);
        check("dbus_we", dbus_we, st);
        check("dbus_wstrb", dbus_wstrb, model_strb(st, int'(t), a));
        check("dbus_wdata", dbus_wdata, model_wdata(st, int'(t), wd));
        check("in_ready_busy", in_ready, 0);
        check("out_valid_early", out_valid, 0);
        dbus_gnt = (g == gd);
        if (!st) begin
          dbus_rvalid = 1'($urandom_range(0, 1));
          dbus_rdata  = $urandom;
        end
        @(negedge clk);
      end
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
      check("dbus_req_drop", dbus_req, 0);
      if (!st) begin
        for (int r = 0; r <= rvd; r++) begin
          check("out_valid_early", out_valid, 0);
          check("in_ready_wait", in_ready, 0);
          dbus_rvalid = (r == rvd);
          dbus_rdata  = (r == rvd) ? rdata : $urandom;
          @(negedge clk);
        end
        dbus_rvalid = 1'b0;
      end
    end else begin
      check("no_dbus_req", dbus_req, 0);
    end
    check("out_valid", out_valid, 1);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    check("out_data", out_data, exp_data);
    check("out_need", out_write_reg_need, exp_need);
    check("out_wra", out_write_reg_addr, wra);
    check("out_err", out_addr_error, err);
    for (int h = 0; h < rdly; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_data);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    if (chain) begin
      in_valid = 1'b1; in_mem_read_ena = 1'b0; in_mem_write_ena = 1'b0;
      in_result = chain_res; in_write_reg_need = 1'b1; in_write_reg_addr = 5'd9;
    end
    #1;
    check("in_ready_release", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (chain) begin
      check("chain_valid", out_valid, 1);
      check("chain_data", out_data, chain_res);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
  endtask

  logic [31:0] stream_v [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mem_read_ena = 1'b0; in_mem_write_ena = 1'b0;
    in_mem_type = 3'd0; in_addr = 32'h0; in_write_data = 32'h0; in_result = 32'h0;
    in_write_reg_need = 1'b0; in_write_reg_addr = 5'd0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_dbus_req", dbus_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back pass-through with out_ready held high.
    stream_v[0] = 32'h1234_5678; stream_v[1] = 32'hCAFE_0001;
    stream_v[2] = 32'h0000_0000; stream_v[3] = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_mem_read_ena = 1'b0; in_mem_write_ena = 1'b0;
      in_result = stream_v[i]; in_write_reg_need = 1'b1; in_write_reg_addr = 5'(5 + i);
      @(negedge clk);
      check("pt_valid", out_valid, 1);
      check("pt_data", out_data, stream_v[i]);
      check("pt_wra", out_write_reg_addr, 5 + i);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pt_drain", out_valid, 0);
    out_ready = 1'b0;

    // Byte loads at 0x1003, signed then unsigned.
    run_pkt(1, 0, 3'd3, 32'h1003, 32'h0, 32'h0, 1, 5'd3, 0, 0, 0, 32'h80AA_BBCC, 0, 32'h0);
    run_pkt(1, 0, 3'd4, 32'h1003, 32'h0, 32'h0, 1, 5'd3, 0, 0, 0, 32'h80AA_BBCC, 0, 32'h0);
    // Half store with a 3-cycle grant delay.
    run_pkt(0, 1, 3'd2, 32'h2002, 32'h0000_BEEF, 32'h55, 0, 5'd0, 3, 0, 0, 32'h0, 0, 32'h0);
    // Misaligned word load.
    run_pkt(1, 0, 3'd0, 32'h3001, 32'h0, 32'h0, 1, 5'd7, 0, 0, 0, 32'h0, 0, 32'h0);
    // Both enables: behaves as a word store.
    run_pkt(1, 1, 3'd0, 32'h4000, 32'hA5A5_1234, 32'h77, 1, 5'd8, 1, 0, 0, 32'h0, 0, 32'h0);
    // Backpressured load, next packet accepted on the release cycle.
    run_pkt(1, 0, 3'd1, 32'h5002, 32'h0, 32'h0, 1, 5'd4, 1, 2, 5, 32'h8001_7FFF, 1, 32'hD00D_F00D);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] kind;
      logic [31:0] a;
      kind = 2'($urandom_range(0, 3));
      a = $urandom;
      run_pkt(kind[0], kind[1], 3'($urandom_range(0, 4)), a, $urandom, $urandom,
              1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
              1'($urandom_range(0, 1)), $urandom);
    end

    // Reset in WAIT abandons the load; a late rvalid must produce nothing.
    in_valid = 1'b1; in_mem_read_ena = 1'b1; in_mem_write_ena = 1'b0;
    in_mem_type = 3'd0; in_addr = 32'h6004; in_write_reg_need = 1'b1; in_write_reg_addr = 5'd2;
    @(negedge clk);
    in_valid = 1'b0; dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_req", dbus_req, 0);
    check("rst_mid_we", dbus_we, 0);
    check("rst_mid_addr", dbus_addr, 0);
    check("rst_mid_wstrb", dbus_wstrb, 0);
    check("rst_mid_wdata", dbus_wdata, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    check("rst_mid_need", out_write_reg_need, 0);
    check("rst_mid_wra", out_write_reg_addr, 0);
    check("rst_mid_err", out_addr_error, 0);
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_rvalid_valid", out_valid, 0);
      check("late_rvalid_req", dbus_req, 0);
      @(negedge clk);
    end
    run_pkt(0, 0, 3'd0, 32'h0, 32'h0, 32'h0BAD_F00D, 1, 5'd1, 0, 0, 0, 32'h0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage that consumes the execute unit's memory request: result, address, store data, type, enables, and register-write info.
- Non-memory ops pass through. Loads and stores run a request/grant/response transaction on the data bus.
- Aligns store data and byte strobes, and extends load data.
- Delivers a registered writeback packet downstream under a valid/ready handshake.

Parameters:
STORE_WAIT_ACK, 0, 1 = a store completes on dbus_rvalid; 0 = a store completes on dbus_gnt.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream packet valid
in_ready  output  1  stage can accept a packet
in_mem_read_ena  input  1  load
in_mem_write_ena  input  1  store
in_mem_type  input  3  0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned
in_addr  input  32  byte address
in_write_data  input  32  store data, right-aligned
in_result  input  32  ALU/link result for non-memory ops
in_write_reg_need  input  1  destination register written
in_write_reg_addr  input  5  destination register
dbus_req  output  1  bus request
dbus_we  output  1  bus write
dbus_addr  output  32  word-aligned address (low 2 bits zero)
dbus_wstrb  output  4  byte strobes
dbus_wdata  output  32  lane-aligned store data
dbus_gnt  input  1  request accepted this cycle
dbus_rvalid  input  1  response/read data valid
dbus_rdata  input  32  read word
out_valid  output  1  writeback packet valid
out_ready  input  1  writeback accepts
out_data  output  32  final result (extended load data or in_result)
out_write_reg_need  output  1  forwarded, forced 0 on addr_error
out_write_reg_addr  output  5  forwarded
out_addr_error  output  1  misaligned access flag

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - in_ready=1.
  - All dbus_* outputs 0.
  - All out_* outputs 0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - Accept on in_valid; latch all inputs.
  - Non-memory op, or both enables 0: go to HOLD next cycle with out_data=in_result and out_valid=1. Latency is 1 cycle.
  - Misaligned access: go to HOLD with out_addr_error=1, out_write_reg_need=0, out_data=in_addr. No bus access. Misaligned means:
    - half with addr[0]=1, or
    - word with addr[1:0]≠0.
  - Aligned memory op: go to REQ.
  - If both enables are 1, the access is treated as a store.
- REQ:
  - dbus_req=1; dbus_addr/we/wstrb/wdata driven from latched values and held stable until dbus_gnt.
  - Strobes:
    - word: 1111.
    - half: 0011 when addr[1]=0, else 1100.
    - byte: 0001 shifted left by addr[1:0].
  - Store data is replicated into lanes: byte×4 or half×2.
  - Loads: wstrb=0000.
  - On dbus_gnt:
    - a load goes to WAIT;
    - a store goes to HOLD if STORE_WAIT_ACK=0, else to WAIT.
  - dbus_req drops the cycle after gnt.
- WAIT:
  - dbus_req=0; wait any number of cycles for dbus_rvalid.
  - Load: select the lane by addr[1:0], sign- or zero-extend per type, latch into out_data, go to HOLD.
  - Store: out_data=in_result, go to HOLD.
  - dbus_rvalid outside WAIT is ignored.
- HOLD:
  - out_valid=1; outputs stable until out_ready.
  - On out_ready, if in_valid is also high the next packet is accepted the same cycle: in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - Handoff with no bubble on the pass-through path.
- in_ready=0 in REQ and WAIT.
- Reset mid-transaction abandons the access. No response is reissued after reset, and a late rvalid is ignored in IDLE.
- Throughput:
  - pass-through ops: 1 per cycle;
  - loads: minimum 3 cycles accept-to-out_valid (grant and rvalid each take 1 cycle).

Test Plan:
1. Pass-through: in_result=0x1234_5678, write_reg_addr=5, out_ready=1 held, back-to-back valid → out_valid at cycle+1, out_data=0x12345678, one packet per cycle.
2. Load byte signed at addr 0x1003, rdata=0x80AA_BBCC, gnt and rvalid 1 cycle each → dbus_addr=0x1000, wstrb=0000, out_data=0xFFFF_FF80. Same with type 4 → 0x0000_0080.
3. Store half at 0x2002, data 0x0000_BEEF, gnt delayed 3 cycles → req/addr/wstrb=1100/wdata=0xBEEF_BEEF stable all 4 cycles; out_valid the cycle after gnt (STORE_WAIT_ACK=0).
4. Word load at 0x3001 → no dbus_req; out_addr_error=1, out_write_reg_need=0, out_data=0x3001.
5. Backpressure: load completes with out_ready=0 for 5 cycles → out_data stable, in_ready=0; when out_ready rises, next in_valid is accepted that cycle.
6. Assert rst during WAIT of a load → all outputs 0 immediately; rvalid=1 after reset causes no out_valid.
